// File: rtl/sha2_round_engine.sv
// -----------------------------------------------------------------------------
// sha2_round_engine
//
// Iterative SHA-2 compression core executing one round per accepted
// (w_in, k_in) pair. W selects SHA-256 (32) or SHA-512 (64) word width and
// sigma rotations; ROUNDS sets the number of rounds per block (1..80).
//
// Optional feature macro: SHA2_FEEDFORWARD_EN
//   defined   : h_out = working registers + saved h_in (word-wise mod 2^W)
//   undefined : h_out = raw working registers; no saved copy is built
//
// Ports
//   clk        : clock, rising edge
//   sha2_reset : asynchronous active-high reset
//   start      : begin a block (sampled only in IDLE)
//   h_in       : initial a..h, a in the MSBs
//   w_in, k_in : schedule word / round constant for the current round
//   wk_valid   : w_in/k_in valid
//   wk_ready   : engine consumes w_in/k_in this cycle (high in RUN)
//   round_idx  : index of the round awaiting w_in/k_in (0 outside RUN)
//   busy       : state is not IDLE
//   done       : one-cycle pulse, h_out valid
//   h_out      : result, a in the MSBs, held until the next done
// -----------------------------------------------------------------------------
module sha2_round_engine #(
    parameter int W      = 64,
    parameter int ROUNDS = 80
) (
    input  logic           clk,
    input  logic           sha2_reset,
    input  logic           start,
    input  logic [8*W-1:0] h_in,
    input  logic [W-1:0]   w_in,
    input  logic [W-1:0]   k_in,
    input  logic           wk_valid,
    output logic           wk_ready,
    output logic [6:0]     round_idx,
    output logic           busy,
    output logic           done,
    output logic [8*W-1:0] h_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int S0_A = (W == 32) ? 2  : 28;
    localparam int S0_B = (W == 32) ? 13 : 34;
    localparam int S0_C = (W == 32) ? 22 : 39;
    localparam int S1_A = (W == 32) ? 6  : 14;
    localparam int S1_B = (W == 32) ? 11 : 18;
    localparam int S1_C = (W == 32) ? 25 : 41;

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        return (x >> n) | (x << (W - n));
    endfunction

    function automatic logic [W-1:0] big_sigma0(input logic [W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ rotr(x, S0_C);
    endfunction

    function automatic logic [W-1:0] big_sigma1(input logic [W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ rotr(x, S1_C);
    endfunction

    function automatic logic [W-1:0] ch(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [W-1:0] maj(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word 7 is 'a' (MSBs), word 0 is 'h', matching the h_in/h_out layout.
    logic [1:0]            state_q, state_d;
    logic [6:0]            idx_q, idx_d;
    logic [7:0][W-1:0]     work_q, work_d;
    logic [7:0][W-1:0]     hout_q, hout_d;
    logic [7:0][W-1:0]     round_next;
    logic [7:0][W-1:0]     result;
    logic [W-1:0]          t1, t2;
`ifdef SHA2_FEEDFORWARD_EN
    logic [7:0][W-1:0]     saved_q, saved_d;
`endif

    // One SHA-2 round on the current working registers.
    always_comb begin
        t1 = work_q[0] + big_sigma1(work_q[3]) + ch(work_q[3], work_q[2], work_q[1])
           + k_in + w_in;
        t2 = big_sigma0(work_q[7]) + maj(work_q[7], work_q[6], work_q[5]);
        round_next[7] = t1 + t2;
        round_next[6] = work_q[7];
        round_next[5] = work_q[6];
        round_next[4] = work_q[5];
        round_next[3] = work_q[4] + t1;
        round_next[2] = work_q[3];
        round_next[1] = work_q[2];
        round_next[0] = work_q[1];
    end

    always_comb begin
`ifdef SHA2_FEEDFORWARD_EN
        for (int i = 0; i < 8; i++) begin
            result[i] = work_q[i] + saved_q[i];
        end
`else
        result = work_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        work_d  = work_q;
        hout_d  = hout_q;
`ifdef SHA2_FEEDFORWARD_EN
        saved_d = saved_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    work_d  = h_in;
`ifdef SHA2_FEEDFORWARD_EN
                    saved_d = h_in;
`endif
                end
            end
            S_RUN: begin
                if (wk_valid) begin
                    work_d = round_next;
                    // round_idx returns to 0 as the block leaves RUN.
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINAL;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            S_FINAL: begin
                hout_d  = result;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge sha2_reset) begin
        if (sha2_reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            work_q  <= '0;
            hout_q  <= '0;
`ifdef SHA2_FEEDFORWARD_EN
            saved_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            hout_q  <= hout_d;
`ifdef SHA2_FEEDFORWARD_EN
            saved_q <= saved_d;
`endif
        end
    end

    assign wk_ready  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign round_idx = idx_q;
    assign h_out     = hout_q;

endmodule

// File: tb/tb_sha2_round_engine.sv
// -----------------------------------------------------------------------------
// tb_sha2_round_engine
//
// Three engine instances share one clock and reset: SHA-256 (W=32, 64
// rounds), SHA-512 (W=64, 80 rounds) and a single-round W=64 engine. 'sel'
// chooses which instance receives start/wk_valid. Expected digests come from
// a plain-arithmetic SHA-2 model (a..h array, round loop) in this file.
// Latency is counted inclusively: the start-sampling edge is edge 1 and the
// edge that raises done is edge ROUNDS+2 (+ stall cycles).
// -----------------------------------------------------------------------------
module tb_sha2_round_engine;

`ifdef SHA2_FEEDFORWARD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // SHA-256 IV and K are the upper halves of the SHA-512 ones.
    localparam logic [63:0] IV512 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [63:0] D256 [8] = '{
        64'hba7816bf, 64'h8f01cfea, 64'h414140de, 64'h5dae2223,
        64'hb00361a3, 64'h96177a9c, 64'hb410ff61, 64'hf20015ad
    };

    localparam logic [63:0] D512 [8] = '{
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start_c;
    logic         wkv_c;
    logic [63:0]  w_c, k_c;
    logic [511:0] hin_c;
    int           sel;

    logic         rdy0, busy0, done0, rdy1, busy1, done1, rdy2, busy2, done2;
    logic [6:0]   idx0, idx1, idx2;
    logic [255:0] ho0;
    logic [511:0] ho1, ho2;

    logic         cur_ready, cur_busy, cur_done;
    logic [6:0]   cur_idx;
    logic [511:0] cur_hout;

    logic [63:0]  mh [8];
    logic [63:0]  mw [80];
    logic [63:0]  mk [80];
    logic [63:0]  exp_h [8];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sha2_round_engine #(.W(32), .ROUNDS(64)) u_s256 (
        .clk(clk), .sha2_reset(rst), .start(start_c && sel == 0), .h_in(hin_c[255:0]),
        .w_in(w_c[31:0]), .k_in(k_c[31:0]), .wk_valid(wkv_c && sel == 0), .wk_ready(rdy0),
        .round_idx(idx0), .busy(busy0), .done(done0), .h_out(ho0));

    sha2_round_engine #(.W(64), .ROUNDS(80)) u_s512 (
        .clk(clk), .sha2_reset(rst), .start(start_c && sel == 1), .h_in(hin_c),
        .w_in(w_c), .k_in(k_c), .wk_valid(wkv_c && sel == 1), .wk_ready(rdy1),
        .round_idx(idx1), .busy(busy1), .done(done1), .h_out(ho1));

    sha2_round_engine #(.W(64), .ROUNDS(1)) u_r1 (
        .clk(clk), .sha2_reset(rst), .start(start_c && sel == 2), .h_in(hin_c),
        .w_in(w_c), .k_in(k_c), .wk_valid(wkv_c && sel == 2), .wk_ready(rdy2),
        .round_idx(idx2), .busy(busy2), .done(done2), .h_out(ho2));

    always_comb begin
        cur_ready = rdy2;
        cur_busy  = busy2;
        cur_done  = done2;
        cur_idx   = idx2;
        cur_hout  = ho2;
        if (sel == 0) begin
            cur_ready = rdy0; cur_busy = busy0; cur_done = done0;
            cur_idx   = idx0; cur_hout = {256'b0, ho0};
        end else if (sel == 1) begin
            cur_ready = rdy1; cur_busy = busy1; cur_done = done1;
            cur_idx   = idx1; cur_hout = ho1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 0) ? 32 : 64;
    endfunction

    function automatic int rounds_of(input int s);
        return (s == 0) ? 64 : ((s == 1) ? 80 : 1);
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    endfunction

    function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n, input int w);
        return ((x >> n) | (x << (w - n))) & mask_of(w);
    endfunction

    function automatic logic [63:0] hout_word(input int w, input int i);
        if (w == 32) return {32'b0, cur_hout[(7 - i) * 32 +: 32]};
        return cur_hout[(7 - i) * 64 +: 64];
    endfunction

    // Reference: a..h as v[0]..v[7], one plain SHA-2 round per loop pass.
    task automatic model_block(input int w, input int rounds);
        logic [63:0] v [8];
        logic [63:0] m, s0, s1, chv, mj, t1, t2;
        m = mask_of(w);
        for (int i = 0; i < 8; i++) v[i] = mh[i];
        for (int r = 0; r < rounds; r++) begin
            if (w == 32) begin
                s0 = rotr_m(v[0], 2, w) ^ rotr_m(v[0], 13, w) ^ rotr_m(v[0], 22, w);
                s1 = rotr_m(v[4], 6, w) ^ rotr_m(v[4], 11, w) ^ rotr_m(v[4], 25, w);
            end else begin
                s0 = rotr_m(v[0], 28, w) ^ rotr_m(v[0], 34, w) ^ rotr_m(v[0], 39, w);
                s1 = rotr_m(v[4], 14, w) ^ rotr_m(v[4], 18, w) ^ rotr_m(v[4], 41, w);
            end
            chv = (v[4] & v[5]) ^ (~v[4] & v[6] & m);
            mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = (v[7] + s1 + chv + mk[r] + mw[r]) & m;
            t2  = (s0 + mj) & m;
            for (int j = 7; j > 0; j--) v[j] = v[j - 1];
            v[4] = (v[4] + t1) & m;
            v[0] = (t1 + t2) & m;
        end
        for (int i = 0; i < 8; i++) exp_h[i] = FF ? ((v[i] + mh[i]) & m) : v[i];
    endtask

    // Padded single-block "abc" message, schedule expanded to 80 words.
    task automatic sched_abc(input int w);
        logic [63:0] m, x2, x15, s0, s1;
        m = mask_of(w);
        for (int i = 0; i < 80; i++) begin
            mw[i] = '0;
            mk[i] = (w == 32) ? (K512[i] >> 32) : K512[i];
        end
        for (int i = 0; i < 8; i++) mh[i] = (w == 32) ? (IV512[i] >> 32) : IV512[i];
        mw[0]  = (w == 32) ? 64'h61626380 : 64'h6162638000000000;
        mw[15] = 64'd24;
        for (int t = 16; t < 80; t++) begin
            x2  = mw[t - 2];
            x15 = mw[t - 15];
            if (w == 32) begin
                s0 = rotr_m(x15, 7, w) ^ rotr_m(x15, 18, w) ^ (x15 >> 3);
                s1 = rotr_m(x2, 17, w) ^ rotr_m(x2, 19, w) ^ (x2 >> 10);
            end else begin
                s0 = rotr_m(x15, 1, w) ^ rotr_m(x15, 8, w) ^ (x15 >> 7);
                s1 = rotr_m(x2, 19, w) ^ rotr_m(x2, 61, w) ^ (x2 >> 6);
            end
            mw[t] = (s1 + mw[t - 7] + s0 + mw[t - 16]) & m;
        end
    endtask

    task automatic randomize_block(input int w);
        logic [63:0] m;
        m = mask_of(w);
        for (int i = 0; i < 8; i++) mh[i] = {$urandom, $urandom} & m;
        for (int i = 0; i < 80; i++) begin
            mw[i] = {$urandom, $urandom} & m;
            mk[i] = {$urandom, $urandom} & m;
        end
    endtask

    task automatic drive_hin(input int w);
        hin_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (w == 32) hin_c[(7 - i) * 32 +: 32] = mh[i][31:0];
            else         hin_c[(7 - i) * 64 +: 64] = mh[i];
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"},  64'(cur_busy),  64'd0);
        check_eq({tag, "_done"},  64'(cur_done),  64'd0);
        check_eq({tag, "_ready"}, 64'(cur_ready), 64'd0);
        check_eq({tag, "_idx"},   64'(cur_idx),   64'd0);
        check_eq({tag, "_hout_a"}, hout_word(width_of(sel), 0), 64'd0);
        check_eq({tag, "_hout_h"}, hout_word(width_of(sel), 7), 64'd0);
    endtask

    // mode: 0 valid always high, 1 toggling 1-0-1-0, 2 random.
    // abort_at >= 0 pulses reset when that many rounds have been consumed.
    task automatic run_block(input int s, input int mode, input int abort_at,
                             input bit hold_start, input string tag);
        int  w, rounds, r, stalls, edges, n;
        bit  v, tog, saw_done;
        w      = width_of(s);
        rounds = rounds_of(s);
        model_block(w, rounds);
        @(negedge clk);
        sel     = s;
        drive_hin(w);
        start_c = 1'b1;
        wkv_c   = 1'b0;
        @(posedge clk);
        #1;
        if (!hold_start) start_c = 1'b0;
        hin_c  = {16{$urandom}};
        edges  = 1;
        check_eq({tag, "_busy_after_start"}, 64'(cur_busy), 64'd1);
        r      = 0;
        stalls = 0;
        tog    = 1'b1;
        while (r < rounds) begin
            @(negedge clk);
            if (r == abort_at) begin
                rst = 1'b1;
                #1;
                check_zero_outputs({tag, "_abort"});
                start_c = 1'b0;
                wkv_c   = 1'b0;
                @(negedge clk);
                rst      = 1'b0;
                saw_done = 1'b0;
                repeat (rounds + 5) begin
                    @(negedge clk);
                    if (cur_done || cur_busy) saw_done = 1'b1;
                end
                check_eq({tag, "_no_done_after_abort"}, 64'(saw_done), 64'd0);
                return;
            end
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) begin v = tog; tog = ~tog; end
            else                v = 1'($urandom_range(0, 1));
            wkv_c = v;
            w_c   = mw[r];
            k_c   = mk[r];
            check_eq({tag, "_ready_run"}, 64'(cur_ready), 64'd1);
            check_eq({tag, "_round_idx"}, 64'(cur_idx), 64'(r));
            @(posedge clk);
            edges++;
            if (v) r++;
            else   stalls++;
        end
        @(negedge clk);
        wkv_c = 1'($urandom_range(0, 1));
        w_c   = {$urandom, $urandom};
        check_eq({tag, "_final_ready"}, 64'(cur_ready), 64'd0);
        check_eq({tag, "_final_idx"},   64'(cur_idx),   64'd0);
        check_eq({tag, "_final_done"},  64'(cur_done),  64'd0);
        n = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            n++;
        end while (!cur_done && n < 8);
        check_eq({tag, "_done_seen"},    64'(cur_done), 64'd1);
        check_eq({tag, "_done_latency"}, 64'(edges), 64'(rounds + 2 + stalls));
        check_eq({tag, "_done_idx"},     64'(cur_idx), 64'd0);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("%s_h_out[%0d]", tag, i), hout_word(w, i), exp_h[i]);
        @(posedge clk);
        #1;
        wkv_c = 1'b0;
        check_eq({tag, "_done_pulse_end"}, 64'(cur_done), 64'd0);
        check_eq({tag, "_idle_after_done"}, 64'(cur_busy), 64'd0);
        check_eq({tag, "_h_out_held"}, hout_word(w, 0), exp_h[0]);
    endtask

    task automatic check_digest(input int s, input string tag);
`ifdef SHA2_FEEDFORWARD_EN
        logic [63:0] d;
        for (int i = 0; i < 8; i++) begin
            d = (s == 0) ? D256[i] : D512[i];
            check_eq($sformatf("%s_digest[%0d]", tag, i), hout_word(width_of(s), i), d);
        end
`else
        if (s < 0) $display("digest %s", tag);
`endif
    endtask

    initial begin
        rst     = 1'b0;
        start_c = 1'b0;
        wkv_c   = 1'b0;
        w_c     = '0;
        k_c     = '0;
        hin_c   = '0;
        sel     = 0;
        #1 rst  = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_zero_outputs($sformatf("reset%0d", s));
        end
        @(negedge clk);
        rst = 1'b0;

        sched_abc(32);
        run_block(0, 0, -1, 1'b0, "abc256");
        check_digest(0, "abc256");

        sched_abc(64);
        run_block(1, 0, -1, 1'b0, "abc512");
        check_digest(1, "abc512");

        for (int i = 0; i < 8; i++) mh[i] = 64'(i + 3);
        mw[0] = 64'd1;
        mk[0] = 64'd2;
        run_block(2, 0, -1, 1'b0, "one_round");
        for (int i = 1; i < 8; i++) begin
            if (i != 4)
                check_eq($sformatf("one_round_shift[%0d]", i), hout_word(64, i),
                         64'(i + 2) + (FF ? 64'(i + 3) : 64'd0));
        end

        sched_abc(32);
        run_block(0, 1, -1, 1'b0, "stall256");
        check_digest(0, "stall256");

        run_block(0, 0, 30, 1'b0, "abort256");
        sched_abc(32);
        run_block(0, 0, -1, 1'b0, "after_abort");
        check_digest(0, "after_abort");

        randomize_block(64);
        run_block(2, 0, -1, 1'b1, "hold_start");
        @(posedge clk);
        #1;
        check_eq("hold_start_rearm_busy", 64'(cur_busy), 64'd1);
        check_eq("hold_start_rearm_idx",  64'(cur_idx),  64'd0);
        start_c = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            randomize_block(width_of(t % 3));
            run_block(t % 3, 2, -1, 1'b0, $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sha2_round_engine.md
SHA2_ROUND_ENGINE -- requirements
Module: sha2_round_engine

Interface
REQ-001 The block SHALL take parameter W, default 64, as the word width; legal values are 32 (SHA-256) and 64 (SHA-512).
REQ-002 The block SHALL take parameter ROUNDS, default 80, as the round count; legal range is 1..80.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port sha2_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a block; sampled only in IDLE.
REQ-006 The block SHALL have port h_in, input, 8*W bits: initial a..h, with a in the MSBs.
REQ-007 The block SHALL have port w_in, input, W bits: message-schedule word for the current round.
REQ-008 The block SHALL have port k_in, input, W bits: round constant for the current round.
REQ-009 The block SHALL have port wk_valid, input, 1 bit: w_in and k_in are valid.
REQ-010 The block SHALL have port wk_ready, output, 1 bit: the engine consumes w_in and k_in this cycle.
REQ-011 The block SHALL have port round_idx, output, 7 bits: index of the round awaiting w_in and k_in.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse marking h_out valid.
REQ-014 The block SHALL have port h_out, output, 8*W bits: result, with a in the MSBs; held until the next done.

Function
REQ-015 States SHALL be IDLE, RUN, FINAL and DONE.
- IDLE to RUN on start: latch h_in into the working registers and the saved copy, and set round_idx to 0.
- RUN: wk_ready is high.
- RUN to FINAL on the handshake where round_idx is ROUNDS-1.
- FINAL to DONE unconditionally.
- DONE to IDLE unconditionally.
REQ-016 A round SHALL execute on each edge where wk_valid and wk_ready are both high, and round_idx SHALL then increment by 1.
REQ-017 In RUN, a cycle with wk_valid low SHALL stall: working registers and round_idx hold.
REQ-018 Each round SHALL compute the following, with all additions mod 2^W:
- T1 = h + S1(e) + Ch(e,f,g) + k_in + w_in
- T2 = S0(a) + Maj(a,b,c)
- new h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
REQ-019 The sigma rotations SHALL depend on W:
- W=32: S0 = ROTR 2^13^22; S1 = ROTR 6^11^25.
- W=64: S0 = ROTR 28^34^39; S1 = ROTR 14^18^41.
REQ-020 In FINAL, h_out SHALL be registered as defined under Configuration.
REQ-021 done SHALL be high exactly during the DONE state.
REQ-022 With wk_valid held high, done SHALL rise ROUNDS+2 edges after the edge that samples start.
REQ-023 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-024 h_in SHALL be sampled only on the IDLE-to-RUN edge; later changes have no effect.
REQ-025 round_idx SHALL read 0 in IDLE, FINAL and DONE.
REQ-026 wk_ready SHALL be low outside RUN, and wk_valid outside RUN SHALL be ignored.
REQ-027 start in the same cycle as the DONE state SHALL be ignored; a new block starts only from IDLE.

Reset
REQ-028 sha2_reset high SHALL immediately force the following, regardless of clk:
- state IDLE
- round_idx 0
- working registers, saved copy and h_out all 0
- done, busy and wk_ready all 0.
REQ-029 Reset mid-RUN SHALL abandon the block, and no done SHALL follow.
REQ-030 After reset release, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-031 With SHA2_FEEDFORWARD_EN defined, h_out SHALL equal working registers + saved h_in, added word-wise mod 2^W.
REQ-032 Without SHA2_FEEDFORWARD_EN, h_out SHALL equal the raw working registers, and the saved copy SHALL NOT be synthesised.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- W=32, ROUNDS=64, FEEDFORWARD_EN, SHA-256 IV, "abc" schedule and constants, wk_valid always high -> h_out=ba7816bf..f20015ad; done exactly 66 edges after start.
- W=64, ROUNDS=80, FEEDFORWARD_EN, SHA-512 IV, "abc" -> h_out=ddaf35a1..a54ca49f.
- W=64, ROUNDS=1, no FEEDFORWARD_EN, h_in=3,4,5,6,7,8,9,10, w_in=1, k_in=2 -> h_out equals the software model of one round; b..d=3,4,5 and f..h=7,8,9.
- Same as the first scenario with wk_valid toggling 1-0-1-0 -> identical h_out; done delayed by the number of stall cycles.
- Reset pulsed at round_idx=30 -> outputs all 0 immediately, no done; the following "abc" run is correct.
- start held high throughout a run -> exactly one block per IDLE entry; no start accepted during DONE.
